pwm_multichannel: RTL
=====================

Name: pwm_multichannel

Overview:
Parametrised multi-channel PWM generator. It is the successor to the fixed 16-output, single-duty PWM peripheral. Each channel has its own duty register, double-buffered and committed at period boundaries. It adds a programmable clock prescaler, edge- or center-aligned counting, and a period-start strobe. The block sits behind the SPI register interface and drives the top-level uo_out/uio_out pins.

Parameters:
NUM_CH, 16, number of PWM channels (1..32)
RES, 8, counter/duty resolution in bits; MAX = 2^RES-1
PRE_W, 8, prescaler divisor width
ADDR_W, 5, config address width; must satisfy 2^ADDR_W >= NUM_CH

Ports:
clk  in  1  system clock
rst  in  1  synchronous active-high reset
out_en  in  NUM_CH  per-channel output enable (level)
pwm_en  in  NUM_CH  per-channel PWM enable (level)
div  in  PRE_W  prescaler divisor; tick every div+1 clocks
center_mode  in  1  0 = edge-aligned, 1 = center-aligned; sampled at period boundary
cfg_we  in  1  duty write strobe
cfg_addr  in  ADDR_W  channel index for duty write
cfg_wdata  in  RES  duty value
out  out  NUM_CH  PWM outputs, registered
period_start  out  1  one-clock pulse when the counter returns to 0

Behaviour:
- Reset, synchronous on rst=1 at a clk edge:
  - pre_cnt, cnt, all shadow and active duties = 0; direction = up; mode_act = 0.
  - out = 0; period_start = 0.
  - Reset asserted mid-period aborts the period immediately with no commit.
- Prescaler:
  - pre_cnt increments each clk.
  - When pre_cnt >= div: tick=1 and pre_cnt <= 0. The >= comparison means that lowering div below the current pre_cnt causes an immediate tick.
  - div=0 gives a tick every clk.
- Edge-aligned counting (mode_act=0):
  - On each tick, cnt increments 0..MAX and wraps to 0.
  - Boundary = tick with cnt==MAX.
  - Period = (MAX+1)*(div+1) clocks.
- Center-aligned counting (mode_act=1):
  - On each tick, cnt counts up 0..MAX, then down MAX-1..1, then back to 0.
  - Direction flips at MAX and at 1.
  - Boundary = tick with direction down and cnt==1.
  - Period = 2*MAX*(div+1) clocks.
- At a boundary, in the same edge as the counter reaching 0:
  - Every active duty loads from its shadow.
  - mode_act loads from center_mode.
  - direction resets to up.
  - period_start = 1 for exactly that one cycle (the first cycle with cnt==0 after a boundary). It is not asserted out of reset.
- Duty writes:
  - cfg_we=1 with cfg_addr < NUM_CH writes cfg_wdata into shadow[cfg_addr] at the clk edge.
  - Writes with cfg_addr >= NUM_CH are ignored.
  - A write in the same cycle as a boundary is not committed by that boundary; the commit samples shadow before the edge, so the write takes effect one period later.
  - Active duty never changes mid-period.
- Per-channel output, computed from pre-edge state and registered (1-clock latency from cnt to out):
  - out_en[i]=0 → 0.
  - out_en[i]=1, pwm_en[i]=0 → 1 (static high).
  - Both enabled: duty==MAX → 1 (100%); otherwise out = (cnt < duty_act[i]).
  - duty=0 → always 0.
- Enable changes (out_en/pwm_en) are not buffered; they take effect 1 clock after they change.
- Edge-mode high time = duty*(div+1) clocks.
- Center-mode high time = (2*duty-1)*(div+1) clocks for 0 < duty < MAX.

Test Plan:
1. Reset, then out_en=all 1, pwm_en=0 → out=all 1s one clock later; with out_en=0 → out=0.
2. Write ch0 duty=0x80, div=0, edge mode, pwm_en[0]=1 → after the first period_start, ch0 is high 128 / low 128 clocks, period 256.
3. Write ch1=0xFF and ch2=0x00 → ch1 is constantly 1 and ch2 is constantly 0 after commit. Write to cfg_addr=20 (NUM_CH=16) → no channel changes.
4. div=3, ch0 duty=0x40 → period_start every 1024 clocks; ch0 high 256 clocks per period.
5. Change ch0 0x40→0xC0 mid-period, and a second write coincident with a boundary → the current period is unchanged; 0xC0 appears from the next period; the coincident write appears one period later.
6. center_mode=1, div=0, duty=0x40 → after the boundary, period 510 clocks with ch0 high 127 contiguous clocks spanning cnt=0. Assert rst mid-period → out=0, cnt=0 next clock, duties cleared.

Source files
------------

// File: rtl/pwm_multichannel.sv
// Multi-channel PWM generator with per-channel double-buffered duty,
// programmable prescaler, and edge- or center-aligned counting.
// Duty writes land in a shadow register. Shadow values, together with the
// counting mode, are committed to the active set only at period boundaries.
module pwm_multichannel #(
    parameter int unsigned NUM_CH = 16,
    parameter int unsigned RES    = 8,
    parameter int unsigned PRE_W  = 8,
    parameter int unsigned ADDR_W = 5
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NUM_CH-1:0] out_en,
    input  logic [NUM_CH-1:0] pwm_en,
    input  logic [PRE_W-1:0]  div,
    input  logic              center_mode,
    input  logic              cfg_we,
    input  logic [ADDR_W-1:0] cfg_addr,
    input  logic [RES-1:0]    cfg_wdata,
    output logic [NUM_CH-1:0] out,
    output logic              period_start
);

    typedef enum logic {
        DIR_UP   = 1'b0,
        DIR_DOWN = 1'b1
    } dir_t;

    localparam logic [RES-1:0] MAX    = '1;
    localparam logic [RES-1:0] MAX_M1 = MAX - 1'b1;
    localparam logic [RES-1:0] ONE    = RES'(1);

    logic [PRE_W-1:0]  r_pre_cnt;
    logic [RES-1:0]    r_cnt;
    dir_t              r_dir;
    logic              r_mode_act;
    logic [RES-1:0]    r_shadow [NUM_CH];
    logic [RES-1:0]    r_active [NUM_CH];
    logic [NUM_CH-1:0] r_out;
    logic              r_period_start;

    logic              w_tick;
    logic              w_boundary;
    logic [NUM_CH-1:0] w_out_next;

    // ">=" lets a lowered divisor fire immediately instead of waiting for wrap
    assign w_tick = (r_pre_cnt >= div);

    // Edge mode ends on MAX; center mode ends on the way down at 1
    assign w_boundary = w_tick &&
                        (r_mode_act ? ((r_dir == DIR_DOWN) && (r_cnt == ONE))
                                    : (r_cnt == MAX));

    // Prescaler: free-running divider producing one tick every div+1 clocks
    always_ff @(posedge clk) begin
        if (rst) begin
            r_pre_cnt <= '0;
        end else if (w_tick) begin
            r_pre_cnt <= '0;
        end else begin
            r_pre_cnt <= r_pre_cnt + 1'b1;
        end
    end

    // Period counter, direction and boundary commit of mode and duties
    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt      <= '0;
            r_dir      <= DIR_UP;
            r_mode_act <= 1'b0;
            for (int unsigned i = 0; i < NUM_CH; i++) begin
                r_active[i] <= '0;
            end
        end else if (w_tick) begin
            if (w_boundary) begin
                r_cnt      <= '0;
                r_dir      <= DIR_UP;
                r_mode_act <= center_mode;
                for (int unsigned i = 0; i < NUM_CH; i++) begin
                    r_active[i] <= r_shadow[i];
                end
            end else if (!r_mode_act) begin
                r_cnt <= r_cnt + 1'b1;
            end else if (r_dir == DIR_UP) begin
                if (r_cnt == MAX) begin
                    r_dir <= DIR_DOWN;
                    r_cnt <= MAX_M1;
                end else begin
                    r_cnt <= r_cnt + 1'b1;
                end
            end else begin
                r_cnt <= r_cnt - 1'b1;
            end
        end
    end

    // Shadow duty writes; addresses beyond the last channel match nothing
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int unsigned i = 0; i < NUM_CH; i++) begin
                r_shadow[i] <= '0;
            end
        end else if (cfg_we) begin
            for (int unsigned i = 0; i < NUM_CH; i++) begin
                if (cfg_addr == ADDR_W'(i)) begin
                    r_shadow[i] <= cfg_wdata;
                end
            end
        end
    end

    // Per-channel output decode from the current counter and active duty
    always_comb begin
        w_out_next = '0;
        for (int unsigned i = 0; i < NUM_CH; i++) begin
            if (!out_en[i]) begin
                w_out_next[i] = 1'b0;
            end else if (!pwm_en[i]) begin
                w_out_next[i] = 1'b1;
            end else if (r_active[i] == MAX) begin
                w_out_next[i] = 1'b1;
            end else begin
                w_out_next[i] = (r_cnt < r_active[i]);
            end
        end
    end

    // Registered outputs and period-start strobe
    always_ff @(posedge clk) begin
        if (rst) begin
            r_out          <= '0;
            r_period_start <= 1'b0;
        end else begin
            r_out          <= w_out_next;
            r_period_start <= w_boundary;
        end
    end

    assign out          = r_out;
    assign period_start = r_period_start;

endmodule
